// File: rtl/ram_pkg.sv
// Shared definitions for the RAM family: controller state encoding, parameter
// legality check and the byte-lane merge used by every write path.
package ram_pkg;

    typedef enum logic {
        ST_CLEAR,
        ST_RUN
    } state_t;

    // Widest word the shared merge helper handles; callers zero-extend.
    localparam int unsigned MERGE_MAX_WIDTH = 256;
    localparam int unsigned MERGE_MAX_BYTES = MERGE_MAX_WIDTH / 8;

    function automatic bit latency_ok(input int unsigned lat);
        return (lat == 1) || (lat == 2);
    endfunction

    function automatic logic [MERGE_MAX_WIDTH-1:0] byte_merge(
        input logic [MERGE_MAX_WIDTH-1:0] old_word,
        input logic [MERGE_MAX_WIDTH-1:0] new_word,
        input logic [MERGE_MAX_BYTES-1:0] be
    );
        logic [MERGE_MAX_WIDTH-1:0] res;
        res = old_word;
        for (int unsigned i = 0; i < MERGE_MAX_BYTES; i++) begin
            if (be[i]) res[i*8 +: 8] = new_word[i*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/ram_dp_rd_pipe.sv
// Per-port read return pipeline: LATENCY-deep valid/data stages, flushed by rst.
// Output data only advances alongside a valid bit, so rdata holds between strobes.
module ram_dp_rd_pipe #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned LATENCY    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rd_en,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rvalid
);

    logic [LATENCY-1:0]    valid_q;
    logic [DATA_WIDTH-1:0] data_q [LATENCY];

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            for (int unsigned i = 0; i < LATENCY; i++) data_q[i] <= '0;
        end else begin
            valid_q[0] <= rd_en;
            if (rd_en) data_q[0] <= rd_data;
            for (int unsigned i = 1; i < LATENCY; i++) begin
                valid_q[i] <= valid_q[i-1];
                if (valid_q[i-1]) data_q[i] <= data_q[i-1];
            end
        end
    end

    assign rvalid = valid_q[LATENCY-1];
    assign rdata  = data_q[LATENCY-1];

endmodule

// File: rtl/ram_dp.sv
// True dual-port synchronous RAM with per-byte write enables, configurable read
// latency, defined cross-port collision behaviour and a post-reset clear sweep.
module ram_dp
    import ram_pkg::*;
#(
    parameter int unsigned DEPTH        = 16,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned WRITE_FIRST  = 0,
    localparam int unsigned ADDR_WIDTH  = $clog2(DEPTH),
    localparam int unsigned BE_WIDTH    = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  busy,
    output logic                  collision,
    input  logic                  a_chip_select,
    input  logic                  a_write_enable,
    input  logic [BE_WIDTH-1:0]   a_byte_en,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_wdata,
    output logic [DATA_WIDTH-1:0] a_rdata,
    output logic                  a_rvalid,
    input  logic                  b_chip_select,
    input  logic                  b_write_enable,
    input  logic [BE_WIDTH-1:0]   b_byte_en,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] b_wdata,
    output logic [DATA_WIDTH-1:0] b_rdata,
    output logic                  b_rvalid
);

    if (!latency_ok(READ_LATENCY)) begin : g_bad_latency
        $error("ram_dp: READ_LATENCY must be 1 or 2");
    end

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    function automatic logic [DATA_WIDTH-1:0] merge(
        input logic [DATA_WIDTH-1:0] old_word,
        input logic [DATA_WIDTH-1:0] new_word,
        input logic [BE_WIDTH-1:0]   be
    );
        logic [MERGE_MAX_WIDTH-1:0] wo, wn, wr;
        logic [MERGE_MAX_BYTES-1:0] wb;
        wo = '0;
        wn = '0;
        wb = '0;
        wo[DATA_WIDTH-1:0] = old_word;
        wn[DATA_WIDTH-1:0] = new_word;
        wb[BE_WIDTH-1:0]   = be;
        wr = byte_merge(wo, wn, wb);
        return wr[DATA_WIDTH-1:0];
    endfunction

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    state_t                state_q, state_n;
    logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_n;
    logic                  clr_we;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_CLEAR;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_n;
            clr_cnt_q <= clr_cnt_n;
        end
    end

    always_comb begin
        state_n   = state_q;
        clr_cnt_n = clr_cnt_q;
        case (state_q)
            ST_CLEAR: begin
                if (clr_cnt_q == LAST_ADDR) state_n = ST_RUN;
                else clr_cnt_n = clr_cnt_q + 1'b1;
            end
            ST_RUN:   state_n = ST_RUN;
            default:  state_n = ST_CLEAR;
        endcase
    end

    always_comb begin
        busy   = (state_q == ST_CLEAR);
        clr_we = (state_q == ST_CLEAR) && !rst;
    end

    logic                  a_ok, b_ok, a_in, b_in, a_wr, b_wr, a_rd, b_rd, same_addr;
    logic [DATA_WIDTH-1:0] a_old, b_old, a_new, b_new, a_rd_data, b_rd_data;

    always_comb begin
        a_ok      = a_chip_select && !busy;
        b_ok      = b_chip_select && !busy;
        a_in      = 32'(a_addr) < DEPTH;
        b_in      = 32'(b_addr) < DEPTH;
        a_wr      = a_ok && a_write_enable && a_in;
        b_wr      = b_ok && b_write_enable && b_in;
        a_rd      = a_ok && !a_write_enable;
        b_rd      = b_ok && !b_write_enable;
        same_addr = (a_addr == b_addr);
        a_old     = a_in ? mem[a_addr] : '0;
        b_old     = b_in ? mem[b_addr] : '0;
        // A is merged on top of B so that lanes enabled on both ports take A's data.
        b_new     = merge(b_old, b_wdata, b_byte_en);
        a_new     = merge((b_wr && same_addr) ? b_new : a_old, a_wdata, a_byte_en);
        a_rd_data = a_old;
        b_rd_data = b_old;
        if (WRITE_FIRST != 0) begin
            if (b_wr && same_addr) a_rd_data = merge(a_old, b_wdata, b_byte_en);
            if (a_wr && same_addr) b_rd_data = merge(b_old, a_wdata, a_byte_en);
        end
    end

    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_cnt_q] <= '0;
        end else if (!rst) begin
            if (b_wr && !(a_wr && same_addr)) mem[b_addr] <= b_new;
            if (a_wr) mem[a_addr] <= a_new;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) collision <= 1'b0;
        else     collision <= a_wr && b_wr && same_addr;
    end

    ram_dp_rd_pipe #(.DATA_WIDTH(DATA_WIDTH), .LATENCY(READ_LATENCY)) u_rd_pipe_a (
        .clk    (clk),
        .rst    (rst),
        .rd_en  (a_rd),
        .rd_data(a_rd_data),
        .rdata  (a_rdata),
        .rvalid (a_rvalid)
    );

    ram_dp_rd_pipe #(.DATA_WIDTH(DATA_WIDTH), .LATENCY(READ_LATENCY)) u_rd_pipe_b (
        .clk    (clk),
        .rst    (rst),
        .rd_en  (b_rd),
        .rd_data(b_rd_data),
        .rdata  (b_rdata),
        .rvalid (b_rvalid)
    );

endmodule
